// File: rtl/ctrl_word_pipe.sv
// Carries the ID-stage control word through EXE, MEM and WB, inserting bubbles on
// squash conditions, holding on memory stall, and counting retired instructions.
module ctrl_word_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       ctrl_in,
    input  logic             one_input_in,
    input  logic [3:0]       dest_in,
    input  logic             valid_in,
    input  logic             cond_pass,
    input  logic             freeze,
    input  logic             flush,
    input  logic             mem_ready,
    output logic [3:0]       exe_alu_cmd,
    output logic             exe_one_input,
    output logic             exe_s,
    output logic             exe_wb_en,
    output logic [3:0]       exe_dest,
    output logic             branch_taken,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_wb_en,
    output logic [3:0]       mem_dest,
    output logic             wb_en,
    output logic             wb_mem_sel,
    output logic [3:0]       wb_dest,
    output logic             stall_out,
    output logic [CNT_W-1:0] retired_cnt
);

    logic             exe_valid_q, exe_valid_d;
    logic [3:0]       exe_alu_q, exe_alu_d;
    logic             exe_rd_q, exe_rd_d;
    logic             exe_wr_q, exe_wr_d;
    logic             exe_wb_q, exe_wb_d;
    logic             exe_br_q, exe_br_d;
    logic             exe_s_q, exe_s_d;
    logic             exe_one_q, exe_one_d;
    logic [3:0]       exe_dest_q, exe_dest_d;

    logic             mem_valid_q, mem_valid_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             mem_wb_q, mem_wb_d;
    logic [3:0]       mem_dest_q, mem_dest_d;

    logic             wb_valid_q, wb_valid_d;
    logic             wb_wb_q, wb_wb_d;
    logic             wb_rd_q, wb_rd_d;
    logic [3:0]       wb_dest_q, wb_dest_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             stall_c;
    logic             branch_c;
    logic             squash_c;

    always_comb begin
        stall_c  = mem_valid_q & (mem_rd_q | mem_wr_q) & ~mem_ready;
        branch_c = exe_valid_q & exe_br_q & ~stall_c;
        squash_c = flush | freeze | ~valid_in | ~cond_pass | branch_c;

        exe_valid_d = exe_valid_q;
        exe_alu_d   = exe_alu_q;
        exe_rd_d    = exe_rd_q;
        exe_wr_d    = exe_wr_q;
        exe_wb_d    = exe_wb_q;
        exe_br_d    = exe_br_q;
        exe_s_d     = exe_s_q;
        exe_one_d   = exe_one_q;
        exe_dest_d  = exe_dest_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wb_d    = mem_wb_q;
        mem_dest_d  = mem_dest_q;
        wb_valid_d  = 1'b0;
        wb_wb_d     = 1'b0;
        wb_rd_d     = 1'b0;
        wb_dest_d   = '0;

        if (!stall_c) begin
            wb_valid_d  = mem_valid_q;
            wb_wb_d     = mem_wb_q;
            wb_rd_d     = mem_rd_q;
            wb_dest_d   = mem_dest_q;
            mem_valid_d = exe_valid_q;
            mem_rd_d    = exe_rd_q;
            mem_wr_d    = exe_wr_q;
            mem_wb_d    = exe_wb_q;
            mem_dest_d  = exe_dest_q;
            if (squash_c) begin
                exe_valid_d = 1'b0;
                exe_alu_d   = '0;
                exe_rd_d    = 1'b0;
                exe_wr_d    = 1'b0;
                exe_wb_d    = 1'b0;
                exe_br_d    = 1'b0;
                exe_s_d     = 1'b0;
                exe_one_d   = 1'b0;
                exe_dest_d  = '0;
            end else begin
                exe_valid_d = 1'b1;
                exe_alu_d   = ctrl_in[8:5];
                exe_rd_d    = ctrl_in[4];
                exe_wr_d    = ctrl_in[3];
                exe_wb_d    = ctrl_in[2];
                exe_br_d    = ctrl_in[1];
                exe_s_d     = ctrl_in[0];
                exe_one_d   = one_input_in;
                exe_dest_d  = dest_in;
            end
        end

        // Counts the instruction currently leaving WB, stalled or not.
        cnt_d = cnt_q + CNT_W'(wb_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q <= 1'b0;
            exe_alu_q   <= '0;
            exe_rd_q    <= 1'b0;
            exe_wr_q    <= 1'b0;
            exe_wb_q    <= 1'b0;
            exe_br_q    <= 1'b0;
            exe_s_q     <= 1'b0;
            exe_one_q   <= 1'b0;
            exe_dest_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wb_q    <= 1'b0;
            mem_dest_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_wb_q     <= 1'b0;
            wb_rd_q     <= 1'b0;
            wb_dest_q   <= '0;
            cnt_q       <= '0;
        end else begin
            exe_valid_q <= exe_valid_d;
            exe_alu_q   <= exe_alu_d;
            exe_rd_q    <= exe_rd_d;
            exe_wr_q    <= exe_wr_d;
            exe_wb_q    <= exe_wb_d;
            exe_br_q    <= exe_br_d;
            exe_s_q     <= exe_s_d;
            exe_one_q   <= exe_one_d;
            exe_dest_q  <= exe_dest_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wb_q    <= mem_wb_d;
            mem_dest_q  <= mem_dest_d;
            wb_valid_q  <= wb_valid_d;
            wb_wb_q     <= wb_wb_d;
            wb_rd_q     <= wb_rd_d;
            wb_dest_q   <= wb_dest_d;
            cnt_q       <= cnt_d;
        end
    end

    assign exe_alu_cmd   = exe_valid_q ? exe_alu_q : '0;
    assign exe_one_input = exe_valid_q & exe_one_q;
    assign exe_s         = exe_valid_q & exe_s_q;
    assign exe_wb_en     = exe_valid_q & exe_wb_q;
    assign exe_dest      = exe_valid_q ? exe_dest_q : '0;
    assign branch_taken  = branch_c;
    assign mem_read      = mem_valid_q & mem_rd_q;
    assign mem_write     = mem_valid_q & mem_wr_q;
    assign mem_wb_en     = mem_valid_q & mem_wb_q;
    assign mem_dest      = mem_valid_q ? mem_dest_q : '0;
    assign wb_en         = wb_valid_q & wb_wb_q;
    assign wb_mem_sel    = wb_valid_q & wb_rd_q;
    assign wb_dest       = wb_valid_q ? wb_dest_q : '0;
    assign stall_out     = stall_c;
    assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// Directed-vector bench for ctrl_word_pipe: one task per scenario, inline checks.
module tb_ctrl_word_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  ctrl_in;
    logic        one_input_in;
    logic [3:0]  dest_in;
    logic        valid_in, cond_pass, freeze, flush, mem_ready;

    logic [3:0]  exe_alu_cmd, exe_dest, mem_dest, wb_dest;
    logic        exe_one_input, exe_s, exe_wb_en, branch_taken;
    logic        mem_read, mem_write, mem_wb_en, wb_en, wb_mem_sel, stall_out;
    logic [15:0] retired_cnt;

    logic [3:0]  w_exe_alu_cmd, w_exe_dest, w_mem_dest, w_wb_dest;
    logic        w_exe_one_input, w_exe_s, w_exe_wb_en, w_branch_taken;
    logic        w_mem_read, w_mem_write, w_mem_wb_en, w_wb_en, w_wb_mem_sel, w_stall_out;
    logic [3:0]  w_retired_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [8:0] ADD = 9'b0010_0_0_1_0_1;
    localparam logic [8:0] LDR = 9'b0010_1_0_1_0_1;
    localparam logic [8:0] BR  = 9'b0000_0_0_0_1_0;
    localparam logic [8:0] MOV = 9'b0001_0_0_1_0_0;

    always #5 clk = ~clk;

    ctrl_word_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .one_input_in(one_input_in),
        .dest_in(dest_in), .valid_in(valid_in), .cond_pass(cond_pass), .freeze(freeze),
        .flush(flush), .mem_ready(mem_ready), .exe_alu_cmd(exe_alu_cmd),
        .exe_one_input(exe_one_input), .exe_s(exe_s), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .branch_taken(branch_taken), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .wb_en(wb_en), .wb_mem_sel(wb_mem_sel), .wb_dest(wb_dest),
        .stall_out(stall_out), .retired_cnt(retired_cnt)
    );

    ctrl_word_pipe #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .one_input_in(one_input_in),
        .dest_in(dest_in), .valid_in(valid_in), .cond_pass(cond_pass), .freeze(freeze),
        .flush(flush), .mem_ready(mem_ready), .exe_alu_cmd(w_exe_alu_cmd),
        .exe_one_input(w_exe_one_input), .exe_s(w_exe_s), .exe_wb_en(w_exe_wb_en),
        .exe_dest(w_exe_dest), .branch_taken(w_branch_taken), .mem_read(w_mem_read),
        .mem_write(w_mem_write), .mem_wb_en(w_mem_wb_en), .mem_dest(w_mem_dest),
        .wb_en(w_wb_en), .wb_mem_sel(w_wb_mem_sel), .wb_dest(w_wb_dest),
        .stall_out(w_stall_out), .retired_cnt(w_retired_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_in = '0; one_input_in = 1'b0; dest_in = '0; valid_in = 1'b0;
        cond_pass = 1'b1; freeze = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({exe_alu_cmd, exe_one_input, exe_s, exe_wb_en, exe_dest, branch_taken, mem_read,
             mem_write, mem_wb_en, mem_dest, wb_en, wb_mem_sel, wb_dest, stall_out} !== 26'd0) begin
            n_bad++; $display("FAIL reset_outputs got nonzero exp=0");
        end
        n_cmp++;
        if (retired_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
        tick();
        rst_n = 1'b1;
        ctrl_in = ADD; valid_in = 1'b1; dest_in = 4'd1;
        tick(); tick(); tick();
        n_cmp++;
        if ({exe_wb_en, mem_wb_en, wb_en} !== 3'b111) begin
            n_bad++; $display("FAIL midflight_fill got=%b exp=111", {exe_wb_en, mem_wb_en, wb_en});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({exe_wb_en, mem_wb_en, wb_en, exe_dest, mem_dest, wb_dest} !== 15'd0) begin
            n_bad++; $display("FAIL async_reset got=%b exp=0",
                              {exe_wb_en, mem_wb_en, wb_en, exe_dest, mem_dest, wb_dest});
        end
        #1;
        rst_n = 1'b1;
        ctrl_in = ADD; valid_in = 1'b1; dest_in = 4'd5;
        tick();
        valid_in = 1'b0;
        tick();
        n_cmp++;
        if (wb_en !== 1'b0) begin n_bad++; $display("FAIL post_reset_early got=%b exp=0", wb_en); end
        tick();
        n_cmp++;
        if (wb_en !== 1'b1 || wb_dest !== 4'd5) begin
            n_bad++; $display("FAIL post_reset_retire got=%b/%0d exp=1/5", wb_en, wb_dest);
        end
    endtask

    task automatic test_add();
        do_reset();
        ctrl_in = ADD; dest_in = 4'd3; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n_cmp++;
        if (exe_alu_cmd !== 4'b0010 || exe_s !== 1'b1 || exe_wb_en !== 1'b1 || exe_dest !== 4'd3) begin
            n_bad++; $display("FAIL add_exe got=%b/%b/%b/%0d exp=0010/1/1/3",
                              exe_alu_cmd, exe_s, exe_wb_en, exe_dest);
        end
        tick();
        n_cmp++;
        if (mem_wb_en !== 1'b1 || mem_dest !== 4'd3 || exe_s !== 1'b0 || mem_read !== 1'b0) begin
            n_bad++; $display("FAIL add_mem got=%b/%0d/%b/%b exp=1/3/0/0",
                              mem_wb_en, mem_dest, exe_s, mem_read);
        end
        tick();
        n_cmp++;
        if (wb_en !== 1'b1 || wb_dest !== 4'd3 || wb_mem_sel !== 1'b0 || retired_cnt !== 16'd0) begin
            n_bad++; $display("FAIL add_wb got=%b/%0d/%b/%0d exp=1/3/0/0",
                              wb_en, wb_dest, wb_mem_sel, retired_cnt);
        end
        tick();
        n_cmp++;
        if (retired_cnt !== 16'd1 || wb_en !== 1'b0) begin
            n_bad++; $display("FAIL add_retire got=%0d/%b exp=1/0", retired_cnt, wb_en);
        end
    endtask

    task automatic test_ldr_stall();
        do_reset();
        ctrl_in = LDR; dest_in = 4'd7; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        mem_ready = 1'b0;
        ctrl_in = ADD; dest_in = 4'd9; valid_in = 1'b1;
        #1;
        n_cmp++;
        if (stall_out !== 1'b1 || mem_read !== 1'b1) begin
            n_bad++; $display("FAIL ldr_stall1 got=%b/%b exp=1/1", stall_out, mem_read);
        end
        tick();
        n_cmp++;
        if (stall_out !== 1'b1 || wb_en !== 1'b0 || mem_dest !== 4'd7) begin
            n_bad++; $display("FAIL ldr_stall2 got=%b/%b/%0d exp=1/0/7", stall_out, wb_en, mem_dest);
        end
        tick();
        n_cmp++;
        if (exe_wb_en !== 1'b0 || wb_en !== 1'b0) begin
            n_bad++; $display("FAIL ldr_hold got=%b/%b exp=0/0", exe_wb_en, wb_en);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin n_bad++; $display("FAIL ldr_release got=%b exp=0", stall_out); end
        tick();
        valid_in = 1'b0;
        n_cmp++;
        if (wb_en !== 1'b1 || wb_mem_sel !== 1'b1 || wb_dest !== 4'd7 || exe_dest !== 4'd9 || mem_wb_en !== 1'b0) begin
            n_bad++; $display("FAIL ldr_wb got=%b/%b/%0d/%0d/%b exp=1/1/7/9/0",
                              wb_en, wb_mem_sel, wb_dest, exe_dest, mem_wb_en);
        end
        tick();
        n_cmp++;
        if (retired_cnt !== 16'd1 || mem_dest !== 4'd9) begin
            n_bad++; $display("FAIL ldr_retire got=%0d/%0d exp=1/9", retired_cnt, mem_dest);
        end
    endtask

    task automatic test_branch();
        do_reset();
        ctrl_in = BR; valid_in = 1'b1;
        tick();
        ctrl_in = ADD; dest_in = 4'd4;
        #1;
        n_cmp++;
        if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL br_pulse got=%b exp=1", branch_taken); end
        tick();
        valid_in = 1'b0;
        n_cmp++;
        if (branch_taken !== 1'b0 || exe_wb_en !== 1'b0 || exe_alu_cmd !== 4'd0 || exe_dest !== 4'd0) begin
            n_bad++; $display("FAIL br_squash got=%b/%b/%0d/%0d exp=0/0/0/0",
                              branch_taken, exe_wb_en, exe_alu_cmd, exe_dest);
        end
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (retired_cnt !== 16'd1 || wb_en !== 1'b0) begin
            n_bad++; $display("FAIL br_retire got=%0d/%b exp=1/0", retired_cnt, wb_en);
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        ctrl_in = LDR; dest_in = 4'd2; valid_in = 1'b1;
        tick();
        ctrl_in = BR;
        tick();
        ctrl_in = ADD; dest_in = 4'd6; mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (branch_taken !== 1'b0 || stall_out !== 1'b1) begin
            n_bad++; $display("FAIL brst_hold got=%b/%b exp=0/1", branch_taken, stall_out);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL brst_fire got=%b exp=1", branch_taken); end
        tick();
        valid_in = 1'b0;
        n_cmp++;
        if (branch_taken !== 1'b0 || exe_wb_en !== 1'b0 || exe_dest !== 4'd0) begin
            n_bad++; $display("FAIL brst_squash got=%b/%b/%0d exp=0/0/0", branch_taken, exe_wb_en, exe_dest);
        end
    endtask

    task automatic test_squash();
        logic [2:0] kind [4] = '{3'b100, 3'b010, 3'b110, 3'b001};
        do_reset();
        ctrl_in = MOV; dest_in = 4'd8; valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            flush = kind[i][2]; freeze = kind[i][1]; cond_pass = ~kind[i][0];
            tick();
            n_cmp++;
            if (exe_alu_cmd !== 4'd0 || exe_wb_en !== 1'b0) begin
                n_bad++; $display("FAIL squash_%0d got=%0d/%b exp=0/0", i, exe_alu_cmd, exe_wb_en);
            end
            flush = 1'b0; freeze = 1'b0; cond_pass = 1'b1;
            tick();
            n_cmp++;
            if (exe_alu_cmd !== 4'b0001 || exe_wb_en !== 1'b1 || exe_dest !== 4'd8) begin
                n_bad++; $display("FAIL squash_recover_%0d got=%0d/%b/%0d exp=1/1/8",
                                  i, exe_alu_cmd, exe_wb_en, exe_dest);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        ctrl_in = ADD; dest_in = 4'd1; valid_in = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        valid_in = 1'b0;
        tick();
        n_cmp++;
        if (w_retired_cnt !== 4'd15) begin n_bad++; $display("FAIL wrap_15 got=%0d exp=15", w_retired_cnt); end
        tick();
        n_cmp++;
        if (w_retired_cnt !== 4'd0) begin n_bad++; $display("FAIL wrap_0 got=%0d exp=0", w_retired_cnt); end
        tick();
        n_cmp++;
        if (w_retired_cnt !== 4'd1 || retired_cnt !== 16'd17) begin
            n_bad++; $display("FAIL wrap_1 got=%0d/%0d exp=1/17", w_retired_cnt, retired_cnt);
        end
        tick();
        n_cmp++;
        if (w_retired_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_idle got=%0d exp=1", w_retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr_stall();
        test_branch();
        test_branch_stall();
        test_squash();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
